ysyx_220066_mem_arb: RTL

Two-requester memory arbiter between the core's instruction-fetch port and its load/store port. It sits between the CPU top and the single shared memory bus, and allows at most one outstanding transaction. It also packs store data with byte masks and sign- or zero-extends load data according to MemOp. It replaces the direct instr/data_Rd wiring, so the core can stall on a multi-cycle memory.

---
 rtl/ysyx_220066_pkg.sv | 32 +++
 rtl/ysyx_220066_mem_arb_if.sv | 41 ++++
 rtl/ysyx_220066_mem_lane.sv | 30 +++
 rtl/ysyx_220066_mem_arb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_pkg.sv
// ysyx_220066_pkg: MemOp encodings, arbiter state and byte-mask helpers shared by the memory arbiter and the LSU.
package ysyx_220066_pkg;

    localparam int MEM_DW = 64;
    localparam int MEM_MW = MEM_DW / 8;

    typedef enum logic [2:0] {
        MEMOP_B  = 3'b000,
        MEMOP_H  = 3'b001,
        MEMOP_W  = 3'b010,
        MEMOP_D  = 3'b011,
        MEMOP_BU = 3'b100,
        MEMOP_HU = 3'b101,
        MEMOP_WU = 3'b110
    } memop_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_LS,
        WAIT_IF,
        WAIT_LS
    } arb_state_e;

    // Unaligned base mask; encodings outside b/h/w (including 111) cover the whole doubleword.
    function automatic logic [MEM_MW-1:0] memop_mask(input logic [2:0] op);
        return (op == MEMOP_B || op == MEMOP_BU) ? 8'h01 :
               (op == MEMOP_H || op == MEMOP_HU) ? 8'h03 :
               (op == MEMOP_W || op == MEMOP_WU) ? 8'h0F : 8'hFF;
    endfunction

endpackage

// File: rtl/ysyx_220066_mem_arb_if.sv
// ysyx_220066_mem_arb_if: fetch, load/store and shared memory bus signals of the arbiter.
interface ysyx_220066_mem_arb_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [2:0]    ls_op;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic            mem_valid;
    logic            mem_ready;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_op, ls_addr, ls_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_op, ls_addr, ls_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_220066_mem_lane.sv
// ysyx_220066_mem_lane: store byte-lane shift/mask and load extract/extend, purely combinational.
module ysyx_220066_mem_lane
    import ysyx_220066_pkg::*;
(
    input  logic [2:0]        st_op,
    input  logic [2:0]        st_off,
    input  logic [MEM_DW-1:0] st_wdata,
    input  logic [2:0]        ld_op,
    input  logic [2:0]        ld_off,
    input  logic [MEM_DW-1:0] ld_rdata,
    output logic [MEM_DW-1:0] st_data,
    output logic [MEM_MW-1:0] st_mask,
    output logic [MEM_DW-1:0] ld_data
);
    logic [MEM_DW-1:0] sh;
    logic is_b, is_h, is_w, sx;

    assign st_data = st_wdata << {st_off, 3'b000};
    assign st_mask = memop_mask(st_op) << st_off;

    assign sh   = ld_rdata >> {ld_off, 3'b000};
    assign is_b = ld_op == MEMOP_B || ld_op == MEMOP_BU;
    assign is_h = ld_op == MEMOP_H || ld_op == MEMOP_HU;
    assign is_w = ld_op == MEMOP_W || ld_op == MEMOP_WU;
    assign sx   = ld_op == MEMOP_B || ld_op == MEMOP_H || ld_op == MEMOP_W;

    assign ld_data = is_b ? {{56{sx & sh[7]}},  sh[7:0]}  :
                     is_h ? {{48{sx & sh[15]}}, sh[15:0]} :
                     is_w ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
endmodule

// File: rtl/ysyx_220066_mem_arb.sv
// ysyx_220066_mem_arb: single-outstanding fetch / load-store arbiter onto the shared memory bus.
// Define YSYX_220066_ARB_RR_EN for round-robin on collisions; otherwise load/store has fixed priority.
module ysyx_220066_mem_arb
    import ysyx_220066_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic clk,
    input  logic rst,
    ysyx_220066_mem_arb_if.slave bus
);
    arb_state_e    state_q, state_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [MEM_MW-1:0] mem_wmask_q, mem_wmask_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    off_q, off_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          ls_rvalid_q, ls_rvalid_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic          idle, ls_pick, if_gnt, ls_gnt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] st_data, ld_data;
    logic [MEM_MW-1:0] st_mask;

    assign idle = state_q == IDLE && !rst;

`ifdef YSYX_220066_ARB_RR_EN
    logic last_ls_q, last_ls_d;
    // On a collision the side that did not win last time goes first.
    assign ls_pick = bus.ls_req && !(bus.if_req && last_ls_q);
    always_comb last_ls_d = (if_gnt || ls_gnt) ? ls_gnt : last_ls_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_ls_q <= 1'b0;
        else     last_ls_q <= last_ls_d;
    end
`else
    assign ls_pick = bus.ls_req;
`endif

    assign ls_gnt   = idle && ls_pick;
    assign if_gnt   = idle && bus.if_req && !ls_pick;
    assign sel_addr = ls_gnt ? bus.ls_addr : bus.if_addr;

    ysyx_220066_mem_lane u_lane (
        .st_op    (bus.ls_op),
        .st_off   (bus.ls_addr[2:0]),
        .st_wdata (bus.ls_wdata),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .ld_rdata (bus.mem_rdata),
        .st_data  (st_data),
        .st_mask  (st_mask),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        op_d        = op_q;
        off_d       = off_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            IDLE: if (if_gnt || ls_gnt) begin
                state_d     = ls_gnt ? REQ_LS : REQ_IF;
                mem_valid_d = 1'b1;
                mem_we_d    = ls_gnt && bus.ls_we;
                mem_addr_d  = {sel_addr[AW-1:3], 3'b000};
                off_d       = sel_addr[2:0];
                op_d        = bus.ls_op;
                mem_wdata_d = mem_we_d ? st_data : '0;
                mem_wmask_d = mem_we_d ? st_mask : '0;
            end
            REQ_IF, REQ_LS: if (bus.mem_ready) begin
                mem_valid_d = 1'b0;
                state_d     = state_q == REQ_IF ? WAIT_IF : WAIT_LS;
            end
            WAIT_IF: if (bus.mem_rvalid) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = off_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                state_d     = IDLE;
            end
            WAIT_LS: if (bus.mem_rvalid) begin
                ls_rvalid_d = 1'b1;
                ls_rdata_d  = mem_we_q ? '0 : ld_data;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            op_q        <= '0;
            off_q       <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            op_q        <= op_d;
            off_q       <= off_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;
endmodule
